// File: rtl/module_pmod_reg_bank.sv
// PMOD SPI register bank: control register with a send/busy FSM plus a shared data buffer.
// Define PMOD_BANK_IRQ_EN to build the sticky transaction-complete interrupt.
module module_pmod_reg_bank #(
  parameter int DEPTH = 16,
  localparam int IW = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          we_i,
  input  logic          re_i,
  input  logic          reg_sel_i,
  input  logic [31:0]   data_i,
  output logic [31:0]   data_o,
  output logic [31:0]   ctrl_o,
  input  logic          spi_we_i,
  input  logic [IW-1:0] spi_idx_i,
  input  logic [31:0]   spi_data_i,
  output logic [31:0]   spi_data_o,
  input  logic          spi_done_i,
  output logic          irq_o
);

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_t;

  localparam logic [9:0] NRX_MAX = 10'(DEPTH);

  state_t        state_q, state_d;
  logic          send_q, send_d;
  logic [1:0]    cs_mode_q, cs_mode_d;
  logic [8:0]    n_tx_q, n_tx_d;
  logic [9:0]    n_rx_q, n_rx_d;
  logic [IW-1:0] wr_ptr_q, wr_ptr_d;
  logic [IW-1:0] rd_ptr_q, rd_ptr_d;
  logic [31:0]   mem_q [DEPTH];

  logic ctrl_wr;
  logic data_wr;
  logic [31:0] ctrl_image;

  assign ctrl_wr = we_i && !reg_sel_i;
  assign data_wr = we_i && reg_sel_i;

  assign ctrl_image = {6'b0, n_rx_q, 3'b0, n_tx_q, cs_mode_q, 1'b0, send_q};

  always_comb begin
    state_d   = state_q;
    send_d    = send_q;
    cs_mode_d = cs_mode_q;
    n_tx_d    = n_tx_q;
    n_rx_d    = n_rx_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;

    if (data_wr) wr_ptr_d = wr_ptr_q + 1'b1;
    if (re_i && reg_sel_i) rd_ptr_d = rd_ptr_q + 1'b1;
    if (spi_we_i && (n_rx_q != NRX_MAX)) n_rx_d = n_rx_q + 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (ctrl_wr) begin
          cs_mode_d = data_i[3:2];
          n_tx_d    = data_i[12:4];
          if (data_i[0]) begin
            // Starting a transaction rewinds both pointers and the receive count
            send_d   = 1'b1;
            state_d  = ST_BUSY;
            n_rx_d   = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
          end
        end
      end
      ST_BUSY: begin
        if (spi_done_i) begin
          state_d = ST_DONE;
          send_d  = 1'b0;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= ST_IDLE;
      send_q    <= 1'b0;
      cs_mode_q <= '0;
      n_tx_q    <= '0;
      n_rx_q    <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
    end else begin
      state_q   <= state_d;
      send_q    <= send_d;
      cs_mode_q <= cs_mode_d;
      n_tx_q    <= n_tx_d;
      n_rx_q    <= n_rx_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
    end
  end

  // SPI write is issued last so it wins a same-entry collision
  always_ff @(posedge clk_i) begin
    if (data_wr) mem_q[wr_ptr_q] <= data_i;
    if (spi_we_i) mem_q[spi_idx_i] <= spi_data_i;
  end

  assign data_o     = reg_sel_i ? mem_q[rd_ptr_q] : ctrl_image;
  assign ctrl_o     = ctrl_image;
  assign spi_data_o = mem_q[spi_idx_i];

`ifdef PMOD_BANK_IRQ_EN
  logic irq_q, irq_d;

  always_comb begin
    irq_d = irq_q;
    if (ctrl_wr && data_i[1]) irq_d = 1'b0;
    if (state_q == ST_BUSY && spi_done_i) irq_d = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) irq_q <= 1'b0;
    else          irq_q <= irq_d;
  end

  assign irq_o = irq_q;
`else
  assign irq_o = 1'b0;
`endif

  logic unused_data;
  assign unused_data = ^{data_i[31:13], data_i[1]};

endmodule
